// File: rtl/reram_activation_buffer.sv
// reram_activation_buffer
//   Captures the per-neuron result stream of the ReRAM layer controller,
//   applies ReLU -> arithmetic right shift -> unsigned saturation, stores one
//   full layer and re-streams it in index order over valid/ready.
//
//   Optional feature macro: RERAM_ACT_ARGMAX_EN (argmax of raw results).
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/idx/value upstream result strobe (no backpressure), index, signed value
//   out_valid/ready    downstream handshake
//   out_data/idx/last  activation, its index, final-element flag
//   frame_done         one-cycle pulse after the last handshake
//   drop_err, dup_err  sticky error flags, cleared by err_clear
//   argmax_valid/idx   index of the largest raw result of the frame
module reram_activation_buffer #(
   parameter int NUM_NEURONS = 256,
   parameter int IDX_W       = 8,
   parameter int IN_W        = 16,
   parameter int OUT_W       = 8,
   parameter int SHIFT       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [IDX_W-1:0]       in_idx,
   input  logic signed [IN_W-1:0] in_value,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_last,
   output logic                   frame_done,
   output logic                   drop_err,
   output logic                   dup_err,
   input  logic                   err_clear,
   output logic                   argmax_valid,
   output logic [IDX_W-1:0]       argmax_idx
);

   localparam logic [0:0] S_COLLECT = 1'b0;
   localparam logic [0:0] S_DRAIN   = 1'b1;

   localparam logic [IDX_W:0]         N_FULL = (IDX_W+1)'(NUM_NEURONS);
   localparam logic [IDX_W-1:0]       N_LAST = IDX_W'(NUM_NEURONS-1);
   localparam logic signed [IN_W-1:0] SAT    = IN_W'((2**OUT_W)-1);

   logic [0:0]             state;
   logic [IDX_W:0]         count;
   logic [IDX_W:0]         count_inc;
   logic [NUM_NEURONS-1:0] bitmap;
   logic [IDX_W-1:0]       rd_ptr;
   logic [OUT_W-1:0]       mem [NUM_NEURONS];

   logic                   idx_ok;
   logic                   is_dup;
   logic                   wr_en;
   logic                   enter_drain;
   logic                   hs;
   logic                   last_hs;
   logic signed [IN_W-1:0] shifted;
   logic [OUT_W-1:0]       act_val;

   // ReLU, shift, saturate; negative inputs never reach the shift result
   assign shifted = in_value >>> SHIFT;
   always_comb begin
      act_val = shifted[OUT_W-1:0];
      if (in_value[IN_W-1])
         act_val = '0;
      else if (shifted > SAT)
         act_val = '1;
   end

   assign idx_ok      = ({1'b0, in_idx} < N_FULL);
   assign is_dup      = bitmap[in_idx];
   assign count_inc   = count + 1'b1;
   assign wr_en       = (state == S_COLLECT) && in_valid && idx_ok;
   assign enter_drain = wr_en && !is_dup && (count_inc == N_FULL);

   assign hs       = out_valid && out_ready;
   assign out_idx  = rd_ptr;
   assign out_last = out_valid && (rd_ptr == N_LAST);
   assign last_hs  = hs && out_last;

   // Activation storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[in_idx] <= act_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_COLLECT;
         count      <= '0;
         bitmap     <= '0;
         rd_ptr     <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state == S_COLLECT) begin
            if (wr_en) begin
               bitmap[in_idx] <= 1'b1;
               if (!is_dup)
                  count <= count_inc;
            end
            if (enter_drain) begin
               state  <= S_DRAIN;
               rd_ptr <= '0;
            end
         end else begin
            if (!out_valid) begin
               // first cycle of DRAIN: prime the output register
               out_valid <= 1'b1;
               out_data  <= mem[rd_ptr];
            end else if (hs) begin
               if (out_last) begin
                  out_valid  <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= S_COLLECT;
                  rd_ptr     <= '0;
                  count      <= '0;
                  bitmap     <= '0;
               end else begin
                  rd_ptr   <= rd_ptr + 1'b1;
                  out_data <= mem[rd_ptr + 1'b1];
               end
            end
         end
      end
   end

   // err_clear wins over a same-cycle error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_err <= 1'b0;
         dup_err  <= 1'b0;
      end else if (err_clear) begin
         drop_err <= 1'b0;
         dup_err  <= 1'b0;
      end else begin
         if (in_valid && (state == S_DRAIN))
            drop_err <= 1'b1;
         if (in_valid && (state == S_COLLECT) && (!idx_ok || is_dup))
            dup_err <= 1'b1;
      end
   end

`ifdef RERAM_ACT_ARGMAX_EN
   localparam logic signed [IN_W-1:0] VAL_MIN = {1'b1, {(IN_W-1){1'b0}}};

   logic signed [IN_W-1:0] max_val;
   logic [IDX_W-1:0]       max_idx;
   logic                   am_valid;
   logic                   better;

   // ties go to the lower index so arrival order does not matter
   assign better = (in_value > max_val) ||
                   ((in_value == max_val) && (in_idx < max_idx));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_val  <= VAL_MIN;
         max_idx  <= '1;
         am_valid <= 1'b0;
      end else if (last_hs) begin
         max_val  <= VAL_MIN;
         max_idx  <= '1;
         am_valid <= 1'b0;
      end else if (wr_en) begin
         if (better) begin
            max_val <= in_value;
            max_idx <= in_idx;
         end
         if (enter_drain)
            am_valid <= 1'b1;
      end
   end

   assign argmax_valid = am_valid;
   assign argmax_idx   = am_valid ? max_idx : '0;
`else
   assign argmax_valid = 1'b0;
   assign argmax_idx   = '0;
`endif

endmodule

// File: tb/tb_reram_activation_buffer.sv
module tb_reram_activation_buffer;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_idx;
   logic signed [15:0] in_value;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic [7:0]        out_idx;
   logic              out_last;
   logic              frame_done;
   logic              drop_err;
   logic              dup_err;
   logic              err_clear;
   logic              argmax_valid;
   logic [7:0]        argmax_idx;

   int checks   = 0;
   int failures = 0;

   // drain bookkeeping
   logic [7:0] got_data [256];
   int hs_cnt, order_err, stall_err, last_cnt, last_at, last_bad, am_low;
   bit fd_after, ov_after, timed_out;

   reram_activation_buffer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
      .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .frame_done(frame_done), .drop_err(drop_err), .dup_err(dup_err),
      .err_clear(err_clear), .argmax_valid(argmax_valid), .argmax_idx(argmax_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int idx, input int val);
      in_valid = 1'b1;
      in_idx   = idx[7:0];
      in_value = val[15:0];
      tick();
      in_valid = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
   // stop_at >= 0: return with ready low once out_idx==stop_at is presented
   task automatic drain(input int mode, input int stop_at);
      bit held, hl, done_now;
      logic [7:0] hd, hi;
      held = 0; hd = 0; hi = 0; hl = 0;
      hs_cnt = 0; order_err = 0; stall_err = 0; last_cnt = 0; last_at = -1;
      last_bad = 0; am_low = 0; fd_after = 0; ov_after = 0; timed_out = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (stop_at >= 0 && out_valid && int'(out_idx) == stop_at) begin
            out_ready = 1'b0;
            return;
         end
         if (held && (out_valid !== 1'b1 || out_data !== hd || out_idx !== hi || out_last !== hl))
            stall_err++;
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
         held = 0;
         if (out_valid) begin
            if (!argmax_valid) am_low++;
            if (out_last && out_idx != 8'd255) last_bad++;
            if (out_ready) begin
               if (int'(out_idx) != hs_cnt) order_err++;
               got_data[out_idx] = out_data;
               if (out_last) begin last_cnt++; last_at = out_idx; end
               hs_cnt++;
            end else begin
               held = 1; hd = out_data; hi = out_idx; hl = out_last;
            end
         end
         done_now = out_valid && out_ready && out_last;
         tick();
         if (done_now) begin
            fd_after  = frame_done;
            ov_after  = out_valid;
            out_ready = 1'b0;
            return;
         end
      end
      timed_out = 1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 0; in_idx = 0; in_value = 0; out_ready = 0; err_clear = 0;
      repeat (3) tick();
      checks++;
      if ({out_valid, out_data, out_idx, out_last, frame_done, drop_err, dup_err, argmax_valid, argmax_idx} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b d=%0d i=%0d l=%b fd=%b de=%b du=%b av=%b ai=%0d want all 0",
                  out_valid, out_data, out_idx, out_last, frame_done, drop_err, dup_err, argmax_valid, argmax_idx);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ramp();
      int bad = 0;
      for (int i = 0; i < 256; i++) send(i, 16 * i);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL ramp_entry_latency out_valid=%b want 0", out_valid); end
      drain(0, -1);
      for (int i = 0; i < 256; i++) if (got_data[i] !== i[7:0]) bad++;
      checks++;
      if (bad != 0 || timed_out) begin failures++; $display("FAIL ramp_data bad=%0d timeout=%0d want 0", bad, timed_out); end
      checks++;
      if (hs_cnt != 256 || order_err != 0) begin failures++; $display("FAIL ramp_count hs=%0d order_err=%0d want 256/0", hs_cnt, order_err); end
      checks++;
      if (last_cnt != 1 || last_at != 255 || last_bad != 0) begin
         failures++; $display("FAIL ramp_last cnt=%0d at=%0d bad=%0d want 1/255/0", last_cnt, last_at, last_bad);
      end
      checks++;
      if (fd_after !== 1'b1 || ov_after !== 1'b0) begin failures++; $display("FAIL ramp_frame_done fd=%b ov=%b want 1/0", fd_after, ov_after); end
      tick();
      checks++;
      if (frame_done !== 1'b0) begin failures++; $display("FAIL ramp_frame_done_pulse fd=%b want 0", frame_done); end
   endtask

   task automatic test_value_edges();
      int vals [6] = '{-5, 15, 16, 4095, 32767, -32768};
      logic [7:0] exp [6] = '{8'd0, 8'd0, 8'd1, 8'd255, 8'd255, 8'd0};
      for (int i = 0; i < 256; i++) send(i, (i < 6) ? vals[i] : 32);
      drain(0, -1);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got_data[i] !== exp[i]) begin
            failures++; $display("FAIL value_edge in=%0d got=%0d want=%0d", vals[i], got_data[i], exp[i]);
         end
      end
      checks++;
      if (got_data[100] !== 8'd2) begin failures++; $display("FAIL value_fill got=%0d want 2", got_data[100]); end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      for (int i = 0; i < 256; i++) send(i, 16 * (255 - i) + 8);
      drain(1, -1);
      for (int i = 0; i < 256; i++) if (got_data[i] !== 8'(255 - i)) bad++;
      checks++;
      if (bad != 0 || timed_out) begin failures++; $display("FAIL bp_data bad=%0d timeout=%0d want 0", bad, timed_out); end
      checks++;
      if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable changes=%0d want 0", stall_err); end
      checks++;
      if (hs_cnt != 256 || order_err != 0) begin failures++; $display("FAIL bp_count hs=%0d order_err=%0d want 256/0", hs_cnt, order_err); end
      checks++;
      if (fd_after !== 1'b1) begin failures++; $display("FAIL bp_frame_done fd=%b want 1", fd_after); end
   endtask

   task automatic test_dup_reverse();
      int bad = 0;
      checks++;
      if (dup_err !== 1'b0) begin failures++; $display("FAIL dup_pre dup_err=%b want 0", dup_err); end
      send(7, 160);
      for (int k = 255; k >= 1; k--) send(k, (k == 7) ? 320 : 16 * k);
      checks++;
      if (dup_err !== 1'b1) begin failures++; $display("FAIL dup_flag dup_err=%b want 1", dup_err); end
      repeat (3) tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL dup_early_drain out_valid=%b want 0", out_valid); end
      send(0, 0);
      drain(0, -1);
      checks++;
      if (got_data[7] !== 8'd20) begin failures++; $display("FAIL dup_overwrite got=%0d want 20", got_data[7]); end
      for (int i = 0; i < 256; i++) if (i != 7 && got_data[i] !== i[7:0]) bad++;
      checks++;
      if (bad != 0 || hs_cnt != 256) begin failures++; $display("FAIL dup_data bad=%0d hs=%0d want 0/256", bad, hs_cnt); end
   endtask

   task automatic test_drop_reset();
      int bad = 0;
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      checks++;
      if (dup_err !== 1'b0 || drop_err !== 1'b0) begin failures++; $display("FAIL clr_dup dup=%b drop=%b want 0/0", dup_err, drop_err); end
      for (int i = 0; i < 256; i++) send(i, 16 * i);
      send(5, 3200);
      checks++;
      if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_flag drop_err=%b want 1", drop_err); end
      drain(0, -1);
      checks++;
      if (got_data[5] !== 8'd5 || hs_cnt != 256) begin failures++; $display("FAIL drop_no_write got=%0d hs=%0d want 5/256", got_data[5], hs_cnt); end
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      checks++;
      if (drop_err !== 1'b0) begin failures++; $display("FAIL drop_clear drop_err=%b want 0", drop_err); end
      // second frame: reset while index 100 is presented
      for (int i = 0; i < 256; i++) send(i, 16 * i + 9);
      drain(0, 100);
      send(1, 1);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 8'd100 || out_data !== 8'd100 || drop_err !== 1'b1) begin
         failures++; $display("FAIL mid_drain v=%b idx=%0d d=%0d drop=%b want 1/100/100/1", out_valid, out_idx, out_data, drop_err);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_data, out_idx, out_last, frame_done, drop_err, dup_err, argmax_valid, argmax_idx} !== '0) begin
         failures++;
         $display("FAIL async_reset v=%b d=%0d i=%0d l=%b fd=%b de=%b du=%b av=%b ai=%0d want all 0",
                  out_valid, out_data, out_idx, out_last, frame_done, drop_err, dup_err, argmax_valid, argmax_idx);
      end
      tick();
      rst = 1'b0;
      tick();
      for (int i = 255; i >= 0; i--) send(i, 16 * ((i + 3) % 256));
      drain(0, -1);
      for (int i = 0; i < 256; i++) if (got_data[i] !== 8'((i + 3) % 256)) bad++;
      checks++;
      if (bad != 0 || hs_cnt != 256 || order_err != 0 || fd_after !== 1'b1) begin
         failures++; $display("FAIL post_reset_frame bad=%0d hs=%0d order=%0d fd=%b want 0/256/0/1", bad, hs_cnt, order_err, fd_after);
      end
   endtask

`ifdef RERAM_ACT_ARGMAX_EN
   task automatic test_argmax();
      for (int i = 0; i < 256; i++) send(i, (i == 42 || i == 200) ? 500 : -100);
      checks++;
      if (argmax_valid !== 1'b1 || argmax_idx !== 8'd42) begin
         failures++; $display("FAIL argmax_entry v=%b idx=%0d want 1/42", argmax_valid, argmax_idx);
      end
      drain(0, -1);
      checks++;
      if (am_low != 0 || hs_cnt != 256) begin failures++; $display("FAIL argmax_hold low_cycles=%0d hs=%0d want 0/256", am_low, hs_cnt); end
      checks++;
      if (argmax_valid !== 1'b0 || fd_after !== 1'b1) begin
         failures++; $display("FAIL argmax_clear v=%b fd=%b want 0/1", argmax_valid, fd_after);
      end
      checks++;
      if (got_data[42] !== 8'd31 || got_data[0] !== 8'd0) begin
         failures++; $display("FAIL argmax_data d42=%0d d0=%0d want 31/0", got_data[42], got_data[0]);
      end
   endtask
`else
   task automatic test_argmax();
      for (int i = 0; i < 256; i++) send(i, (i == 42) ? 500 : -100);
      checks++;
      if (argmax_valid !== 1'b0 || argmax_idx !== 8'd0) begin
         failures++; $display("FAIL argmax_off v=%b idx=%0d want 0/0", argmax_valid, argmax_idx);
      end
      drain(0, -1);
      checks++;
      if (got_data[42] !== 8'd31 || got_data[0] !== 8'd0 || hs_cnt != 256) begin
         failures++; $display("FAIL argmax_off_data d42=%0d d0=%0d hs=%0d want 31/0/256", got_data[42], got_data[0], hs_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ramp();
      test_value_edges();
      test_backpressure();
      test_dup_reverse();
      test_drop_reset();
      test_argmax();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reram_activation_buffer.md
Name: reram_activation_buffer

Overview:
- Sits directly downstream of the ReRAM layer controller and consumes its per-neuron result stream (valid, idx, signed 16-bit value).
- Applies ReLU, then an arithmetic right shift, then saturation to unsigned 8-bit.
- Buffers one full layer of activations and re-streams them in index order over a valid/ready interface.
- The output stream matches the pixel-input format of the next layer's controller.

Parameters:
- NUM_NEURONS, 256, activations per frame; must be ≤ 2^IDX_W.
- IDX_W, 8, width of neuron index.
- IN_W, 16, signed input result width.
- OUT_W, 8, unsigned output activation width.
- SHIFT, 4, right-shift amount applied after ReLU.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  one-cycle strobe per neuron result; no backpressure exists upstream.
- in_idx  input  IDX_W  neuron index of in_value.
- in_value  input  IN_W  signed neuron result.
- out_valid  output  1  activation available.
- out_ready  input  1  downstream accepts when out_valid&&out_ready.
- out_data  output  OUT_W  activation value.
- out_idx  output  IDX_W  index of out_data.
- out_last  output  1  high with the final activation of the frame.
- frame_done  output  1  one-cycle pulse after the last handshake.
- drop_err  output  1  sticky: an in_valid arrived during DRAIN.
- dup_err  output  1  sticky: the same idx was written twice in one frame.
- err_clear  input  1  clears drop_err and dup_err.
- argmax_valid  output  1  argmax result valid (see Optional Feature).
- argmax_idx  output  IDX_W  index of the largest raw result.

Behaviour:
- Reset (rst high, asynchronous): state=COLLECT, count=0, valid bitmap=0, rd_ptr=0.
  - All outputs 0: out_valid, out_data, out_idx, out_last, frame_done, drop_err, dup_err, argmax_valid, argmax_idx.
  - Buffer contents are not reset.
- Reset mid-frame: any partial frame is discarded, and the bench sees a clean COLLECT state.
- Activation function (combinational at capture):
  - a = (in_value < 0) ? 0 : in_value >>> SHIFT.
  - If a > 2^OUT_W-1, then a = 2^OUT_W-1.
  - Only the stored 8-bit value is kept.
- State COLLECT:
  - On in_valid, write act(in_value) to buf[in_idx] and set bitmap[in_idx].
  - If bitmap[in_idx] was already set: overwrite the entry, set dup_err, and leave count unchanged.
  - Otherwise count++.
  - When a write makes count reach NUM_NEURONS, go to DRAIN on the next cycle with rd_ptr=0.
  - in_idx ≥ NUM_NEURONS is ignored and sets dup_err.
- State DRAIN:
  - out_data=buf[rd_ptr] and out_idx=rd_ptr, registered.
  - out_valid rises 1 cycle after entry, and out_data is valid in the same cycle (1-cycle buffer read latency).
  - While out_valid && !out_ready: out_data, out_idx and out_last hold stable.
  - On a handshake, rd_ptr++ and the next entry is presented in the following cycle.
  - Throughput is 1 activation/cycle when out_ready is held high, with no bubbles after the first.
  - out_last = (rd_ptr == NUM_NEURONS-1) && out_valid.
  - On the out_last handshake:
    - out_valid=0 next cycle.
    - frame_done pulses 1 cycle.
    - bitmap and count clear.
    - state returns to COLLECT in the same cycle frame_done is high.
  - in_valid during DRAIN: data dropped, drop_err set, no buffer write.
- Errors:
  - err_clear has priority over a same-cycle error set, so that cycle's error is lost.
  - drop_err and dup_err never clear otherwise, except by reset.
- Simultaneous events: in_valid in the same cycle as the out_last handshake is dropped and drop_err is set, because the state is still DRAIN.

Optional Feature:
- Macro: RERAM_ACT_ARGMAX_EN.
- Defined:
  - During COLLECT, track the maximum raw signed in_value (pre-ReLU, full IN_W) and its index.
  - Ties keep the lower index.
  - Duplicate writes compare normally.
  - At DRAIN entry, argmax_valid=1 and argmax_idx holds the result until frame_done, when argmax_valid=0.
  - Tracker resets to the most-negative value at the start of each frame.
- Undefined: argmax_valid and argmax_idx are tied to 0, and no comparator logic exists.

Test Plan:
- Ramp frame: idx i with value 16*i for i=0..255, out_ready=1.
  - Required: out_data = min(i,255) for all i, out_last only at idx 255, frame_done 1 cycle after that handshake.
- Value edges:
  - -5 gives out_data 0.
  - 15 gives 0.
  - 16 gives 1.
  - 4095 gives 255.
  - 32767 gives 255 (saturation).
- Backpressure: out_ready toggles 1,0,0,1 repeating.
  - Required: data/idx stable while stalled, no skipped or repeated idx, 256 handshakes total.
- Out-of-order plus duplicate: indices sent in reverse order, with idx 7 written twice (first 160, last 320).
  - Required: out_data[7]=20, dup_err=1, DRAIN starts only after all 256 unique idx have been written.
- Drop and reset:
  - in_valid during DRAIN sets drop_err=1 with buffer unchanged.
  - err_clear clears drop_err.
  - rst asserted at rd_ptr=100 gives all outputs 0 immediately, and the next full frame streams correctly.
- With RERAM_ACT_ARGMAX_EN:
  - All values -100, except idx 42=500 and idx 200=500.
  - Required: argmax_idx=42, argmax_valid high through DRAIN, low after frame_done.
